// File: rtl/sound_scheduler_pkg.sv
// Shared types and helpers for the sound scheduler.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package audio_pkg;

    typedef enum logic [1:0] {
        SND_NONE = 2'd0,
        SND_JUMP = 2'd1,
        SND_WIN  = 2'd2,
        SND_LOSE = 2'd3
    } sound_id_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    // Length in clocks of a sound id; SND_NONE maps to 1 so callers never underflow.
    function automatic int unsigned sound_len(input logic [1:0] id,
                                              input int unsigned jump_len,
                                              input int unsigned win_len,
                                              input int unsigned lose_len);
        case (id)
            SND_JUMP: sound_len = jump_len;
            SND_WIN:  sound_len = win_len;
            SND_LOSE: sound_len = lose_len;
            default:  sound_len = 1;
        endcase
    endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Bundle of game-event levels, tone generator taps and scheduler outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels.
interface sound_scheduler_if;
    import audio_pkg::*;

    logic       jumpForward;
    logic       jumpBackward;
    logic       jumpRight;
    logic       jumpLeft;
    logic       win;
    logic       lose;
    logic       mute;
    logic       jumpSoundIn;
    logic       winSoundIn;
    logic       loseSoundIn;
    logic       enableJumpSound;
    logic       enableWinSound;
    logic       enableLoseSound;
    logic [1:0] soundId;
    logic       busy;
    logic       sound;

    // Game side: drives levels and generator taps, observes the scheduler.
    modport master (
        output jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose, mute,
        output jumpSoundIn, winSoundIn, loseSoundIn,
        input  enableJumpSound, enableWinSound, enableLoseSound, soundId, busy, sound
    );

    // Scheduler side.
    modport slave (
        input  jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose, mute,
        input  jumpSoundIn, winSoundIn, loseSoundIn,
        output enableJumpSound, enableWinSound, enableLoseSound, soundId, busy, sound
    );
endinterface

// File: rtl/sound_scheduler_rise_detect.sv
// Per-bit rising-edge detector producing a one-cycle pulse.
// Latency: combinational pulse in the cycle the level is first seen high.
// Backpressure: none; a held level yields a single pulse.
module rise_detect #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] rise_o
);
    logic [WIDTH-1:0] prev_q;

    // Remember last cycle's level; cleared on reset so a level high at release fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= level_i;
    end

    assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/sound_scheduler.sv
// Priority scheduler for jump/win/lose tone generators with timed play and silent gap.
// Latency: enable/soundId/busy rise one edge after the triggering level is sampled.
// Backpressure: none; lower-priority events during play are dropped, events in gap are pended.
module sound_scheduler
    import audio_pkg::*;
#(
    parameter int unsigned JUMP_CYCLES = 5_000_000,
    parameter int unsigned WIN_CYCLES  = 50_000_000,
    parameter int unsigned LOSE_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 500_000
) (
    input  logic          clk,
    input  logic          resetN,
    sound_scheduler_if.slave sif
);
    localparam int unsigned MAX_JW  = (JUMP_CYCLES > WIN_CYCLES) ? JUMP_CYCLES : WIN_CYCLES;
    localparam int unsigned MAX_JWL = (MAX_JW > LOSE_CYCLES) ? MAX_JW : LOSE_CYCLES;
    localparam int unsigned MAX_LEN = (MAX_JWL > GAP_CYCLES) ? MAX_JWL : GAP_CYCLES;
    localparam int          CW      = $clog2(MAX_LEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [5:0]    rise;
    logic [1:0]    ev_id;
    logic [1:0]    best;
    logic [1:0]    state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [1:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_jump_q, en_win_q, en_lose_q, busy_q;
    logic [1:0]    sound_id_q;

    rise_detect #(.WIDTH(6)) u_rise (
        .clk     (clk),
        .rst_n   (resetN),
        .level_i ({sif.lose, sif.win, sif.jumpLeft, sif.jumpRight,
                   sif.jumpBackward, sif.jumpForward}),
        .rise_o  (rise)
    );

    // Only the highest-priority event of the cycle survives.
    always_comb begin
        ev_id = SND_NONE;
        if (rise[5])        ev_id = SND_LOSE;
        else if (rise[4])   ev_id = SND_WIN;
        else if (|rise[3:0]) ev_id = SND_JUMP;
        best = (ev_id > pend_q) ? ev_id : pend_q;
    end

    // Next-state: start, preempt/retrigger, expire into gap, and pend during gap.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                pend_d = SND_NONE;
                if (best != SND_NONE) begin
                    state_d = ST_PLAY;
                    cur_d   = best;
                    cnt_d   = CW'(sound_len(best, JUMP_CYCLES, WIN_CYCLES, LOSE_CYCLES) - 1);
                end
            end
            ST_PLAY: begin
                if (ev_id > cur_q) begin
                    cur_d = ev_id;
                    cnt_d = CW'(sound_len(ev_id, JUMP_CYCLES, WIN_CYCLES, LOSE_CYCLES) - 1);
                end else if (ev_id == SND_JUMP && cur_q == SND_JUMP) begin
                    cnt_d = CW'(JUMP_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cur_d   = SND_NONE;
                    cnt_d   = CW'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (ev_id > pend_q) pend_d = ev_id;
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                state_d = ST_IDLE;
                cur_d   = SND_NONE;
                pend_d  = SND_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers plus outputs decoded from next-state so they line up with it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            cur_q      <= SND_NONE;
            pend_q     <= SND_NONE;
            cnt_q      <= '0;
            en_jump_q  <= 1'b0;
            en_win_q   <= 1'b0;
            en_lose_q  <= 1'b0;
            busy_q     <= 1'b0;
            sound_id_q <= SND_NONE;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            en_jump_q  <= (cur_d == SND_JUMP);
            en_win_q   <= (cur_d == SND_WIN);
            en_lose_q  <= (cur_d == SND_LOSE);
            busy_q     <= (state_d != ST_IDLE);
            sound_id_q <= cur_d;
        end
    end

    // Speaker: selected generator tap, silenced by mute or when nothing plays.
    always_comb begin
        case (sound_id_q)
            SND_JUMP: sif.sound = sif.jumpSoundIn & ~sif.mute;
            SND_WIN:  sif.sound = sif.winSoundIn  & ~sif.mute;
            SND_LOSE: sif.sound = sif.loseSoundIn & ~sif.mute;
            default:  sif.sound = 1'b0;
        endcase
    end

    assign sif.enableJumpSound = en_jump_q;
    assign sif.enableWinSound  = en_win_q;
    assign sif.enableLoseSound = en_lose_q;
    assign sif.soundId         = sound_id_q;
    assign sif.busy            = busy_q;
endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Arbitrates and sequences the game's three tone generators (jump, win, lose) from raw game-event levels. It turns level inputs into rising-edge events, grants the audio path to one sound at a time by fixed priority, and plays each sound for a fixed duration. A short silent gap follows each sound. The block sits between game logic and the tone generators: it drives their enables and selects the single-bit speaker output.

## Interface
- `JUMP_CYCLES`, default 5_000_000: jump sound length in clocks (0.1 s at 50 MHz); must be ≥1.
- `WIN_CYCLES`, default 50_000_000: win sound length in clocks; must be ≥1.
- `LOSE_CYCLES`, default 50_000_000: lose sound length in clocks; must be ≥1.
- `GAP_CYCLES`, default 500_000: silence after each sound; must be ≥1.
- `clk  in  1`: system clock.
- `resetN  in  1`: asynchronous, active-low reset.
- `jumpForward, jumpBackward, jumpRight, jumpLeft  in  1 each`: level inputs.
- `win  in  1`: level input.
- `lose  in  1`: level input.
- `mute  in  1`: forces `sound` low. Scheduling is unaffected.
- `jumpSoundIn, winSoundIn, loseSoundIn  in  1 each`: tone generator outputs.
- `enableJumpSound, enableWinSound, enableLoseSound  out  1 each`: registered. At most one is high.
- `soundId  out  2`: registered. 0 = none, 1 = jump, 2 = win, 3 = lose.
- `busy  out  1`: registered. High in PLAY or GAP.
- `sound  out  1`: the selected generator input ANDed with ~mute. It is 0 when no sound is selected.

## Operation
- **Edge detection.** Each input has a previous-value register. An event fires in a cycle where the input is 1 and its previous value is 0. The jump event is the OR of the four direction edges.
- **Priority.** lose > win > jump.
- **States.** The FSM has three states: IDLE, PLAY, and GAP. It also holds `cur` (the current sound id), `pend` (a 2-bit pending sound id, 0 = none), and a down-counter whose width is `$clog2` of the largest parameter + 1.
- **IDLE.** The highest-priority event (or `pend`, if it is higher) becomes `cur`. The counter loads `<SOUND>_CYCLES-1` and the state moves to PLAY. `pend` clears.
- **PLAY, preemption.** An event with priority above `cur` replaces `cur` and reloads the counter.
- **PLAY, jump retrigger.** A jump event while `cur`=jump reloads the counter (restart).
- **PLAY, ignored events.** A win event while `cur`=win is ignored, as is a lose event while `cur`=lose. Lower-priority events are dropped; they are not pended.
- **PLAY, expiry.** When the counter is 0 and there is no preempting event, the state moves to GAP, the counter loads `GAP_CYCLES-1`, and `cur` becomes 0.
- **GAP.** An event updates `pend` to the maximum of `pend` and the event id. When the counter is 0, the state moves to IDLE.
- **Simultaneous events.** Only the highest-priority event is acted on. The others are discarded.
- **Outputs.** The enables, `soundId`, and `busy` are decoded from next-state/next-`cur` and registered. `sound` is a combinational mux on the registered `soundId`.

## Timing
- **Reset.** Asserting reset forces IDLE immediately, at any time, including mid-sound. All registered outputs go to 0, `cur`=0, `pend`=0, and the counter is 0. Previous-value registers reset to 0, so an input already high at release produces an event on the first clock.
- **Start latency.** An input first sampled high at edge N raises the matching enable after edge N. `busy`=1 and `soundId` are valid from the same edge.
- **Sound length.** An uninterrupted sound holds its enable high for exactly `<SOUND>_CYCLES` cycles. `busy` then stays high for exactly `GAP_CYCLES` more cycles, then drops.
- **Preemption.** On preemption, the old enable falls and the new enable rises at the same edge, with no zero-enable cycle between them.
- **Pending.** A pended event starts one cycle after the GAP→IDLE transition, because IDLE consumes `pend`. So `busy` has a single low cycle between the two sounds.
- **Held inputs.** A level held high produces only one event.

## Structure
- **Package `audio_pkg`.** Holds the `sound_id_e` enum (SND_NONE=0, SND_JUMP=1, SND_WIN=2, SND_LOSE=3), the `sched_state_e` enum (IDLE, PLAY, GAP), and a `sound_len` function that maps an id to its cycle-count parameter.
- **Sub-module `rise_detect`.** Parameterized width, asynchronous active-low reset, outputs a one-cycle pulse per bit. It is instantiated once, 6 bits wide.
- **Generators.** The existing tone generators stay outside this block.

## Test plan
All scenarios use JUMP=4, WIN=10, LOSE=12, GAP=3.

- **Single jump.** Pulse `jumpLeft` high for 20 cycles → `enableJumpSound` is high for exactly 4 cycles starting 1 edge after the rise. `busy` is high for 7 cycles. There is exactly one event despite the held level.
- **Preempt.** Raise `win` at cycle 0, then `lose` at cycle 5 → win enable is high for cycles 1–5 and lose enable rises at edge 6 with no gap. Lose lasts 12 cycles, and `soundId` goes 2→3→0.
- **Simultaneous.** `jumpForward`, `win`, and `lose` rise at the same edge → only lose plays. After the gap, `busy`=0 and nothing else plays.
- **Pend in GAP.** Jump ends, then `win` rises in GAP cycle 1 → win starts one cycle after GAP ends and plays for 10 cycles.
- **Retrigger and drop.** Raise `jumpRight` at cycle 0 and `jumpLeft` at cycle 2 → the jump enable spans 6 cycles. A jump event during WIN is dropped.
- **Mute/reset.** With `mute`=1, the enables behave normally and `sound`=0. Asserting `resetN` low mid-LOSE drops all outputs to 0 immediately; after release, the block is IDLE.
